// File: rtl/bus_dma_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_dma_master_pkg
// Description : Shared FSM state encoding and bus request type constants for
//               the DMA master and the accelerator's slave decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_dma_master_pkg;

    // Copy engine states; explicit width so the slave decoder can share it.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RD_GAP = 3'd2,
        ST_WR     = 3'd3,
        ST_WR_GAP = 3'd4,
        ST_DONE   = 3'd5
    } dma_state_t;

    // Bus request kinds as seen by the slave decoder.
    typedef enum logic [1:0] {
        BUS_REQ_NONE  = 2'd0,
        BUS_REQ_READ  = 2'd1,
        BUS_REQ_WRITE = 2'd2
    } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/bus_dma_master_packet_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dma_packet_buffer
// Description : Single-entry packet register between the read and write
//               phases of a copy. Loaded on read completion, marked empty on
//               write completion.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_packet_buffer #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid
);
    import bus_dma_master_pkg::*;

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Capture read data; a load in the same cycle as a clear keeps the entry full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= data_in;
            r_valid <= 1'b1;
        end else if (clear) begin
            r_valid <= 1'b0;
        end
    end

    assign data_out = r_data;
    assign valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/bus_dma_master.sv
`default_nettype none
// ============================================================================
// Module      : bus_dma_master
// Description : Bus initiator copying cfg_len packets from cfg_src_addr to
//               cfg_dst_addr, one read then one write per packet, with a
//               single idle cycle after every bus transaction.
//               Optional watchdog enabled by defining DMA_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_dma_master #(
    parameter int BUS_PACKET_WIDTH = 256,
    parameter int ADDR_WIDTH       = 32,
    parameter int LEN_WIDTH        = 16,
    parameter int ADDR_STRIDE      = 1
`ifdef DMA_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES   = 1024
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       cfg_src_addr,
    input  logic [ADDR_WIDTH-1:0]       cfg_dst_addr,
    input  logic [LEN_WIDTH-1:0]        cfg_len,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [ADDR_WIDTH-1:0]       bus_master_addr,
    output logic                        bus_master_read_request,
    output logic                        bus_master_write_request,
    output logic [BUS_PACKET_WIDTH-1:0] bus_master_output,
    input  logic [BUS_PACKET_WIDTH-1:0] bus_master_input,
    input  logic                        bus_master_request_finish
);
    import bus_dma_master_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] C_STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

    dma_state_t              r_state;
    logic [ADDR_WIDTH-1:0]   r_src_ptr;
    logic [ADDR_WIDTH-1:0]   r_dst_ptr;
    logic [LEN_WIDTH-1:0]    r_remaining;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_rd_req;
    logic                    r_wr_req;
    logic                    r_busy;
    logic                    r_done;

    logic                        w_buf_load;
    logic                        w_buf_clear;
    logic                        w_buf_valid;
    logic [BUS_PACKET_WIDTH-1:0] w_buf_data;

`ifdef DMA_TIMEOUT_EN
    localparam int                C_WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_WDOG_W-1:0] C_WDOG_LAST = C_WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [C_WDOG_W-1:0] r_wdog;
    logic                r_error;
`endif

    // Finish only counts while the matching request is outstanding.
    assign w_buf_load  = (r_state == ST_RD) && bus_master_request_finish;
    assign w_buf_clear = (r_state == ST_WR) && bus_master_request_finish;

    dma_packet_buffer #(
        .WIDTH (BUS_PACKET_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (w_buf_load),
        .clear    (w_buf_clear),
        .data_in  (bus_master_input),
        .data_out (w_buf_data),
        .valid    (w_buf_valid)
    );

    // Copy sequencer: every output is registered so requests change only on edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_addr      <= '0;
            r_rd_req    <= 1'b0;
            r_wr_req    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef DMA_TIMEOUT_EN
            r_wdog      <= '0;
            r_error     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_src_ptr   <= cfg_src_addr;
                        r_dst_ptr   <= cfg_dst_addr;
                        r_remaining <= cfg_len;
                        r_busy      <= 1'b1;
`ifdef DMA_TIMEOUT_EN
                        r_error     <= 1'b0;
                        r_wdog      <= '0;
`endif
                        if (cfg_len == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state  <= ST_RD;
                            r_addr   <= cfg_src_addr;
                            r_rd_req <= 1'b1;
                        end
                    end
                end

                ST_RD: begin
                    if (bus_master_request_finish) begin
                        r_rd_req <= 1'b0;
                        r_state  <= ST_RD_GAP;
                    end
`ifdef DMA_TIMEOUT_EN
                    else if (r_wdog == C_WDOG_LAST) begin
                        r_rd_req <= 1'b0;
                        r_error  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog + C_WDOG_W'(1);
                    end
`endif
                end

                ST_RD_GAP: begin
                    if (w_buf_valid) begin
                        r_state  <= ST_WR;
                        r_addr   <= r_dst_ptr;
                        r_wr_req <= 1'b1;
`ifdef DMA_TIMEOUT_EN
                        r_wdog   <= '0;
`endif
                    end
                end

                ST_WR: begin
                    if (bus_master_request_finish) begin
                        r_wr_req    <= 1'b0;
                        r_src_ptr   <= r_src_ptr + C_STRIDE;
                        r_dst_ptr   <= r_dst_ptr + C_STRIDE;
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        r_state     <= ST_WR_GAP;
                    end
`ifdef DMA_TIMEOUT_EN
                    else if (r_wdog == C_WDOG_LAST) begin
                        r_wr_req <= 1'b0;
                        r_error  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog + C_WDOG_W'(1);
                    end
`endif
                end

                ST_WR_GAP: begin
                    if (r_remaining != '0) begin
                        r_state  <= ST_RD;
                        r_addr   <= r_src_ptr;
                        r_rd_req <= 1'b1;
`ifdef DMA_TIMEOUT_EN
                        r_wdog   <= '0;
`endif
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                // Arriving from a finished copy done is already high and drops here;
                // a zero-length copy arrives with done low and pulses it now.
                ST_DONE: begin
                    r_done  <= ~r_done;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_rd_req <= 1'b0;
                    r_wr_req <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign busy                     = r_busy;
    assign done                     = r_done;
    assign bus_master_addr          = r_addr;
    assign bus_master_read_request  = r_rd_req;
    assign bus_master_write_request = r_wr_req;
    assign bus_master_output        = w_buf_data;

`ifdef DMA_TIMEOUT_EN
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_dma_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_dma_master
// Description : Self-checking bench for bus_dma_master: randomized slave
//               latency, transaction-list reference model, per-cycle checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_dma_master;
    localparam int W = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   cfg_src_addr = '0;
    logic [31:0]   cfg_dst_addr = '0;
    logic [15:0]   cfg_len = '0;
    logic          busy, done, error;
    logic [31:0]   bus_master_addr;
    logic          bus_master_read_request, bus_master_write_request;
    logic [W-1:0]  bus_master_output;
    logic [W-1:0]  bus_master_input = '0;
    logic          bus_master_request_finish = 1'b0;

    always #5 clk = ~clk;

    bus_dma_master #(
        .BUS_PACKET_WIDTH (W),
        .ADDR_WIDTH       (32),
        .LEN_WIDTH        (16),
        .ADDR_STRIDE      (1)
`ifdef DMA_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES   (8)
`endif
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .cfg_src_addr              (cfg_src_addr),
        .cfg_dst_addr              (cfg_dst_addr),
        .cfg_len                   (cfg_len),
        .busy                      (busy),
        .done                      (done),
        .error                     (error),
        .bus_master_addr           (bus_master_addr),
        .bus_master_read_request   (bus_master_read_request),
        .bus_master_write_request  (bus_master_write_request),
        .bus_master_output         (bus_master_output),
        .bus_master_input          (bus_master_input),
        .bus_master_request_finish (bus_master_request_finish)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [W-1:0] data;
    } txn_t;

    txn_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          slave_never = 1'b0;
    bit          allow_abort = 1'b0;
    int          stall_fixed = -1;
    int          lat_max = 3;
    int unsigned seed = 32'h1234_5678;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Memory contents: a deterministic function of address and per-copy seed.
    function automatic logic [W-1:0] mem_fn(input logic [31:0] a);
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++)
            r[i*32 +: 32] = (a * 32'(i + 1)) ^ seed ^ (32'(i) << 24);
        return r;
    endfunction

    function automatic logic [W-1:0] garbage();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: the copy is the ordered list read(src+i), write(dst+i, mem[src+i]).
    task automatic build_exp(input logic [31:0] src, input logic [31:0] dst, input int len);
        for (int i = 0; i < len; i++) begin
            txn_t t;
            logic [31:0] sa;
            sa = src + 32'(i);
            t.wr = 1'b0; t.addr = sa; t.data = '0;
            exp_q.push_back(t);
            t.wr = 1'b1; t.addr = dst + 32'(i); t.data = mem_fn(sa);
            exp_q.push_back(t);
        end
    endtask

    // Slave responder and per-cycle checker.
    initial begin : slave_monitor
        bit          pending;
        int          stall, lat, stage;
        logic        rd, wr, h_wr;
        logic [31:0] h_addr;
        logic [W-1:0] h_out;
        pending = 0; stall = 0; lat = 0; stage = 0;
        h_wr = 0; h_addr = '0; h_out = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pending = 0;
                stage = 0;
                bus_master_request_finish = 1'b0;
            end else begin
                rd = bus_master_read_request;
                wr = bus_master_write_request;
                chk("one_request", W'(rd && wr), '0);
                if (stage == 1) begin
                    chk("req_deassert", W'(rd || wr), '0);
                    stage = 2;
                end else if (stage == 2) begin
                    if (exp_q.size() > 0) chk("gap_one_cycle", W'(rd || wr), W'(1));
                    stage = 0;
                end
                if (done) begin
                    chk("done_busy_low", W'(busy), '0);
                    if (!allow_abort) chk("done_all_txn", W'(exp_q.size()), '0);
`ifndef DMA_TIMEOUT_EN
                    chk("error_tied", W'(error), '0);
`endif
                end
                if (rd || wr) begin
                    chk("busy_with_req", W'(busy), W'(1));
                    if (pending) begin
                        chk("hold_addr", W'(bus_master_addr), W'(h_addr));
                        chk("hold_kind", W'(wr), W'(h_wr));
                        if (wr) chk("hold_data", bus_master_output, h_out);
                    end else begin
                        chk("unexpected_req", W'(exp_q.size() == 0), '0);
                        if (exp_q.size() > 0) begin
                            chk("txn_kind", W'(wr), W'(exp_q[0].wr));
                            chk("txn_addr", W'(bus_master_addr), W'(exp_q[0].addr));
                        end
                        pending = 1; stall = 0;
                        h_wr = wr; h_addr = bus_master_addr; h_out = bus_master_output;
                        lat = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, lat_max));
                    end
                    if (!slave_never && stall >= lat) begin
                        bus_master_request_finish = 1'b1;
                        bus_master_input = rd ? mem_fn(bus_master_addr) : garbage();
                        if (wr && exp_q.size() > 0) chk("wr_data", bus_master_output, exp_q[0].data);
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        pending = 0;
                        stage = 1;
                    end else begin
                        bus_master_request_finish = 1'b0;
                        bus_master_input = garbage();
                        stall++;
                    end
                end else begin
                    pending = 0;
                    bus_master_request_finish = ($urandom_range(0, 7) == 0);
                    bus_master_input = garbage();
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] src, input logic [31:0] dst, input int len);
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        start = 1'b1;
        cfg_src_addr = src; cfg_dst_addr = dst; cfg_len = 16'(len);
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", W'(busy), W'(1));
        chk("error_cleared", W'(error), '0);
    endtask

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input bit mid, output int elapsed);
        int  c0;
        bit  got;
        seed = $urandom;
        build_exp(src, dst, len);
        pulse_start(src, dst, len);
        c0 = cyc;
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (mid && i == 2) begin
                start = 1'b1;
                cfg_src_addr = ~src; cfg_dst_addr = ~dst; cfg_len = 16'd7;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1;
        end
        start = 1'b0;
        chk("done_seen", W'(got), W'(1));
        elapsed = cyc - c0;
        if (!got) exp_q.delete();
    endtask

    initial begin : main
        int el;
        bit got;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_error", W'(error), '0);
        chk("rst_rd_req", W'(bus_master_read_request), '0);
        chk("rst_wr_req", W'(bus_master_write_request), '0);
        chk("rst_addr", W'(bus_master_addr), '0);
        chk("rst_output", bus_master_output, '0);
        rst = 1'b1;

        // Three packets, zero-wait slave: 4 cycles per packet.
        stall_fixed = 0;
        run_copy(32'h100, 32'h200, 3, 0, el);
        chk("len3_cycles", W'(el), W'(12));

        // Empty copy: one busy cycle then done.
        run_copy(32'h100, 32'h200, 0, 0, el);
        chk("len0_cycles", W'(el), W'(1));

        // Every transaction stalls 5 cycles.
        stall_fixed = 5;
        run_copy(32'h40, 32'h80, 2, 0, el);
        chk("stall5_cycles", W'(el), W'(28));

        // Start mid-copy must be ignored.
        stall_fixed = -1;
        run_copy(32'h100, 32'h200, 3, 1, el);

        // Address wrap-around.
        run_copy(32'hFFFF_FFFE, 32'hFFFF_FFFF, 4, 0, el);

        // Reset during a write, then restart from new config.
        seed = $urandom;
        build_exp(32'h300, 32'h400, 4);
        pulse_start(32'h300, 32'h400, 4);
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus_master_write_request) got = 1;
        end
        chk("saw_write", W'(got), W'(1));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr_req", W'(bus_master_write_request), '0);
        chk("rst_mid_rd_req", W'(bus_master_read_request), '0);
        chk("rst_mid_busy", W'(busy), '0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        run_copy(32'h500, 32'h600, 2, 0, el);

        // Randomized copies.
        for (int k = 0; k < 6; k++)
            run_copy($urandom, $urandom, int'($urandom_range(1, 6)), 0, el);

`ifdef DMA_TIMEOUT_EN
        begin
            int nreq;
            slave_never = 1'b1;
            allow_abort = 1'b1;
            seed = $urandom;
            build_exp(32'h700, 32'h800, 3);
            pulse_start(32'h700, 32'h800, 3);
            nreq = bus_master_read_request ? 1 : 0;
            got = 0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (bus_master_read_request) nreq++;
                if (done) got = 1;
            end
            chk("to_done", W'(got), W'(1));
            chk("to_req_cycles", W'(nreq), W'(8));
            chk("to_error", W'(error), W'(1));
            exp_q.delete();
            slave_never = 1'b0;
            allow_abort = 1'b0;
            run_copy(32'h10, 32'h20, 1, 0, el);
            chk("to_error_after", W'(error), '0);
        end
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : global_bound
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
